// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: opcodes, the fetch FSM state type and
// immediate decoders used by the fetch stage and its branch predictor.
package riscv_pkg;

   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_HOLD,
      ST_FLUSH
   } fetch_state_e;

   function automatic logic [31:0] b_imm(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] j_imm(input logic [31:0] instr);
      return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/ifetch_bpred.sv
// Static jal / 2-bit-counter conditional branch predictor for the fetch stage.
// Only instantiated when IFETCH_BPRED_EN is defined.
module bpred
   import riscv_pkg::*;
#(
   parameter int BHT_ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] fetch_pc,
   input  logic [31:0] fetch_instr,
   input  logic        bp_update,
   input  logic [31:0] bp_update_pc,
   input  logic        bp_taken,
   output logic [31:0] next_pc,
   output logic        pred_taken
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [BHT_ENTRIES-1:0][1:0] bht_q;
   logic [BHT_ENTRIES-1:0][1:0] bht_d;
   logic [IDX_W-1:0]            fetch_idx;
   logic [IDX_W-1:0]            upd_idx;
   logic [31:0]                 seq_pc;
   logic [31:0]                 target;
   logic                        unused_upd_pc;

   assign fetch_idx     = fetch_pc[IDX_W+1:2];
   assign upd_idx       = bp_update_pc[IDX_W+1:2];
   assign unused_upd_pc = ^{bp_update_pc[31:IDX_W+2], bp_update_pc[1:0]};

   // Counters saturate at 0 and 3; the training read sees last cycle's value.
   always_comb begin
      bht_d = bht_q;
      if (bp_update) begin
         if (bp_taken && bht_q[upd_idx] != 2'd3) begin
            bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
         end else if (!bp_taken && bht_q[upd_idx] != 2'd0) begin
            bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
         end
      end
   end

   always_comb begin
      seq_pc = fetch_pc + 32'd4;
      target = seq_pc;
      if (fetch_instr[6:0] == OP_JAL) begin
         target = fetch_pc + j_imm(fetch_instr);
      end else if (fetch_instr[6:0] == OP_BRANCH && bht_q[fetch_idx][1]) begin
         target = fetch_pc + b_imm(fetch_instr);
      end
      next_pc    = target;
      pred_taken = (target != seq_pc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bht_q <= {BHT_ENTRIES{2'b01}};
      end else begin
         bht_q <= bht_d;
      end
   end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: request FSM, one-entry skid buffer and redirect flush.
// Define IFETCH_BPRED_EN to enable jal/branch prediction through bpred.
module ifetch
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BHT_ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        bp_update,
   input  logic [31:0] bp_update_pc,
   input  logic        bp_taken,
   output logic [31:0] instr,
   output logic [31:0] pc_if2id,
   output logic        pred_taken_if2id,
   output logic        ide_wait
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  flush_pc_q, flush_pc_d;
   logic         req_q, req_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  pc_out_q, pc_out_d;
   logic         pred_out_q, pred_out_d;
   logic         wait_q, wait_d;
   logic         skid_valid_q, skid_valid_d;
   logic [31:0]  skid_instr_q, skid_instr_d;
   logic [31:0]  skid_pc_q, skid_pc_d;
   logic         skid_pred_q, skid_pred_d;
   logic [31:0]  next_pc;
   logic         pred_taken;

`ifdef IFETCH_BPRED_EN
   bpred #(
      .BHT_ENTRIES (BHT_ENTRIES)
   ) u_bpred (
      .clk          (clk),
      .rst_n        (rst_n),
      .fetch_pc     (pc_q),
      .fetch_instr  (imem_rdata),
      .bp_update    (bp_update),
      .bp_update_pc (bp_update_pc),
      .bp_taken     (bp_taken),
      .next_pc      (next_pc),
      .pred_taken   (pred_taken)
   );
`else
   logic unused_cfg;
   assign unused_cfg = ^{bp_update, bp_update_pc, bp_taken, (BHT_ENTRIES > 0)};
   assign next_pc    = pc_q + 32'd4;
   assign pred_taken = 1'b0;
`endif

   // A redirect beats everything; an unacked request must still drain in FLUSH.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      flush_pc_d   = flush_pc_q;
      instr_d      = instr_q;
      pc_out_d     = pc_out_q;
      pred_out_d   = pred_out_q;
      wait_d       = wait_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      skid_pred_d  = skid_pred_q;
      if (redirect) begin
         wait_d       = 1'b1;
         skid_valid_d = 1'b0;
         if (state_q == ST_REQ && !imem_ack) begin
            state_d    = ST_FLUSH;
            flush_pc_d = redirect_pc;
         end else if (state_q == ST_FLUSH && !imem_ack) begin
            flush_pc_d = redirect_pc;
         end else begin
            state_d = ST_REQ;
            pc_d    = redirect_pc;
         end
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
               if (imem_ack) begin
                  pc_d = next_pc;
                  if (stall) begin
                     skid_valid_d = 1'b1;
                     skid_instr_d = imem_rdata;
                     skid_pc_d    = pc_q;
                     skid_pred_d  = pred_taken;
                     state_d      = ST_HOLD;
                  end else begin
                     instr_d    = imem_rdata;
                     pc_out_d   = pc_q;
                     pred_out_d = pred_taken;
                     wait_d     = 1'b0;
                  end
               end else if (!stall) begin
                  wait_d = 1'b1;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  instr_d      = skid_instr_q;
                  pc_out_d     = skid_pc_q;
                  pred_out_d   = skid_pred_q;
                  wait_d       = !skid_valid_q;
                  skid_valid_d = 1'b0;
                  state_d      = ST_REQ;
               end
            end
            ST_FLUSH: begin
               if (imem_ack) begin
                  pc_d    = flush_pc_q;
                  state_d = ST_REQ;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      req_d = (state_d == ST_REQ) || (state_d == ST_FLUSH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         flush_pc_q   <= RESET_PC;
         req_q        <= 1'b0;
         instr_q      <= NOP_INSTR;
         pc_out_q     <= 32'h0;
         pred_out_q   <= 1'b0;
         wait_q       <= 1'b1;
         skid_valid_q <= 1'b0;
         skid_instr_q <= NOP_INSTR;
         skid_pc_q    <= 32'h0;
         skid_pred_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         flush_pc_q   <= flush_pc_d;
         req_q        <= req_d;
         instr_q      <= instr_d;
         pc_out_q     <= pc_out_d;
         pred_out_q   <= pred_out_d;
         wait_q       <= wait_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         skid_pred_q  <= skid_pred_d;
      end
   end

   assign imem_req         = req_q;
   assign imem_addr        = pc_q;
   assign instr            = instr_q;
   assign pc_if2id         = pc_out_q;
   assign pred_taken_if2id = pred_out_q;
   assign ide_wait         = wait_q;

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BHT_ENTRIES, 16, branch-history entries (power of 2), indexed by pc[log2(BHT_ENTRIES)+1:2].
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  instruction memory request.
REQ-006 imem_addr  out  32  fetch address, held stable while imem_req=1 until imem_ack.
REQ-007 imem_ack  in  1  rdata valid this cycle, completes request.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 stall  in  1  decode/execute hazard, hold fetch outputs.
REQ-010 redirect  in  1  execute-resolved mispredict or jalr target.
REQ-011 redirect_pc  in  32  corrected fetch address.
REQ-012 bp_update, bp_update_pc[31:0], bp_taken  in  1/32/1  resolved-branch training.
REQ-013 instr  out  32  instruction to decode.
REQ-014 pc_if2id  out  32  address of instr.
REQ-015 pred_taken_if2id  out  1  fetch predicted instr taken.
REQ-016 ide_wait  out  1  1 = instr is a bubble, decode must not act.

Function
REQ-017 FSM states: IDLE, REQ, HOLD, FLUSH; IDLE -> REQ unconditionally next cycle.
REQ-018 REQ: imem_req=1, imem_addr=pc.
REQ-019 REQ, ack, no stall, no redirect: instr<=imem_rdata, pc_if2id<=pc, ide_wait<=0, pc<=next_pc, stay REQ; throughput one instruction per ack, latency one cycle ack-to-output.
REQ-020 REQ, no ack, no stall: ide_wait<=1 next cycle, instr/pc_if2id hold.
REQ-021 stall=1: instr, pc_if2id, pred_taken_if2id, ide_wait hold.
REQ-022 Ack during stall: word, pc and prediction go to one-entry skid buffer, pc<=next_pc, go HOLD, imem_req=0.
REQ-023 HOLD, stall falls: skid drives outputs next cycle, ide_wait<=0, return REQ.
REQ-024 Redirect has highest priority: pc<=redirect_pc, skid invalidated, ide_wait<=1 next cycle.
REQ-025 Redirect with ack same cycle or in HOLD/IDLE: rdata discarded, go REQ at redirect_pc.
REQ-026 Redirect in REQ without ack: go FLUSH, keep imem_req=1 with old address, discard data on ack, then REQ at saved redirect_pc.
REQ-027 Redirect overrides stall; outputs become bubble regardless of stall.
REQ-028 next_pc default pc+4, 32-bit wrap (32'hFFFF_FFFC+4 = 0).
REQ-029 pred_taken_if2id=1 only when next_pc != pc+4 by prediction.

Reset
REQ-030 rst_n low: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=32'h0000_0013, pc_if2id=0, pred_taken_if2id=0, ide_wait=1, skid invalid, BHT all 2'b01.
REQ-031 Reset mid-request abandons it; any later ack is ignored until state REQ.

Configuration
REQ-032 Macro IFETCH_BPRED_EN.
REQ-033 Defined: opcode 1101111 (jal) -> next_pc=pc+J-imm; opcode 1100011 with BHT counter>=2 -> next_pc=pc+B-imm; bp_update trains counter at bp_update_pc, saturating 0..3 (+1 taken, -1 not).
REQ-034 Undefined: next_pc=pc+4 always, pred_taken_if2id=0, bp_* inputs ignored, no BHT storage.

Structure
REQ-035 Shared package riscv_pkg: opcode constants OP_BRANCH, OP_JAL, NOP_INSTR, fetch state enum, B/J immediate extraction functions.
REQ-036 Sub-module bpred: BHT array, counter update, target computation; instantiated only under IFETCH_BPRED_EN.

Verification
REQ-037 Reset release, ack every cycle, words 0x00100093, 0x00200113 -> pc_if2id 0x0 then 0x4, ide_wait low from cycle after first ack.
REQ-038 stall high 3 cycles, ack during stall -> outputs frozen, HOLD entered, skid word appears cycle after stall falls, no word lost or duplicated.
REQ-039 Redirect to 0x100 while request to 0x8 unacked -> FLUSH, 0x8 data discarded, next imem_addr 0x100.
REQ-040 Redirect and stall together -> ide_wait=1 next cycle, next fetch 0x100.
REQ-041 BPRED: bp_update taken twice at 0x10, then fetch beq at 0x10 with B-imm -8 -> next imem_addr 0x8, pred_taken_if2id=1; jal at 0x20 imm +0x40 -> next 0x60.
REQ-042 pc 0xFFFF_FFFC, non-branch -> next imem_addr 0x0.
